// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared constants, state type and grant helpers for the
//               data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  // Arbiter state encoding
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_G0   = 2'd1;
  localparam logic [1:0] ARB_G1   = 2'd2;

  // Upper 24 address bits that select the memory-mapped IO window
  localparam logic [23:0] IO_BASE_HI = 24'hffffff;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_G0   = ARB_G0,
    ST_G1   = ARB_G1
  } arb_state_t;

  // Grant state for a given owner index
  function automatic arb_state_t grant_state(input logic owner);
    return owner ? ST_G1 : ST_G0;
  endfunction

  // One-hot grant vector for a given owner index
  function automatic logic [1:0] grant_vec(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arb_rr.sv
// ============================================================================
// Module      : dmem_arb_rr
// Description : Two-way round-robin grant FSM with a per-grant transfer
//               limit. Grants are Moore outputs registered with the state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_rr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic       o_xfer
);

  localparam int                 c_CNT_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_HOLD);

  arb_state_t         r_state;
  logic [1:0]         r_gnt;
  logic               r_last;      // owner of the most recent transfer
  logic [c_CNT_W-1:0] r_cnt;       // transfers in the current grant

  logic               w_own;
  logic               w_own_req;
  logic               w_oth_req;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic               w_limit;

  // Current owner and its / the other master's request
  assign w_own     = (r_state == ST_G1);
  assign w_own_req = i_req[w_own];
  assign w_oth_req = i_req[~w_own];

  // Saturating increment; limit is reached when this transfer hits MAX_HOLD
  assign w_cnt_inc = (r_cnt == c_MAX_CNT) ? r_cnt : r_cnt + c_CNT_W'(1);
  assign w_limit   = (w_cnt_inc == c_MAX_CNT);

  assign o_gnt  = r_gnt;
  assign o_xfer = |(r_gnt & i_req);

  // Grant FSM: state, registered grants, last owner and hold counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;             // m0 wins the first tie
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (i_req[0] && i_req[1]) begin
            r_state <= grant_state(~r_last);
            r_gnt   <= grant_vec(~r_last);
          end else if (i_req[0]) begin
            r_state <= ST_G0;
            r_gnt   <= 2'b01;
          end else if (i_req[1]) begin
            r_state <= ST_G1;
            r_gnt   <= 2'b10;
          end
        end

        ST_G0, ST_G1: begin
          if (!w_own_req) begin
            // Owner released: hand over or go idle, no transfer this cycle
            r_cnt <= '0;
            if (w_oth_req) begin
              r_state <= grant_state(~w_own);
              r_gnt   <= grant_vec(~w_own);
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= 2'b00;
            end
          end else begin
            // Transfer cycle
            r_last <= w_own;
            if (w_limit && w_oth_req) begin
              r_state <= grant_state(~w_own);
              r_gnt   <= grant_vec(~w_own);
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 2'b00;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares one data-memory / IO port between two masters using
//               round-robin with a per-grant transfer limit. Muxes the
//               request onto the memory side and steers the one-cycle read
//               return back to the issuing master.
//               Optional macro DMEM_ARB_IO_PROTECT_EN blocks m1 accesses to
//               the IO window and flags them on arb_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dataout,

  output logic              arb_err
);

  logic [1:0]        w_gnt;
  logic              w_xfer;
  logic              w_we_raw;
  logic              w_blocked;
  logic [DATA_W-1:0] w_m1_rd_live;

  logic              r_m0_rvalid;
  logic              r_m1_rvalid;
  logic              r_m1_rblk;    // pending m1 read was blocked
  logic [DATA_W-1:0] r_m0_rhold;
  logic [DATA_W-1:0] r_m1_rhold;

  dmem_arb_rr #(
    .MAX_HOLD (MAX_HOLD)
  ) u_rr (
    .clock  (clock),
    .reset  (reset),
    .i_req  ({m1_req, m0_req}),
    .o_gnt  (w_gnt),
    .o_xfer (w_xfer)
  );

  assign m0_gnt = w_gnt[0];
  assign m1_gnt = w_gnt[1];

  // Memory-side mux: owner's request, all zero when idle
  always_comb begin
    mem_addr   = '0;
    mem_datain = '0;
    w_we_raw   = 1'b0;
    if (w_gnt[0]) begin
      mem_addr   = m0_addr;
      mem_datain = m0_wdata;
      w_we_raw   = m0_req & m0_we;
    end else if (w_gnt[1]) begin
      mem_addr   = m1_addr;
      mem_datain = m1_wdata;
      w_we_raw   = m1_req & m1_we;
    end
  end

`ifdef DMEM_ARB_IO_PROTECT_EN
  // m1 transfer into the IO window (top 24 address bits all ones)
  assign w_blocked = w_gnt[1] & m1_req & (m1_addr[ADDR_W-1 -: 24] == IO_BASE_HI);
`else
  assign w_blocked = 1'b0;
`endif

  assign mem_we  = w_we_raw & ~w_blocked;
  assign arb_err = w_blocked;

  // Read-return tags and held read data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m1_rblk   <= 1'b0;
      r_m0_rhold  <= '0;
      r_m1_rhold  <= '0;
    end else begin
      r_m0_rvalid <= w_xfer & w_gnt[0] & ~m0_we;
      r_m1_rvalid <= w_xfer & w_gnt[1] & ~m1_we;
      r_m1_rblk   <= w_blocked & ~m1_we;
      if (r_m0_rvalid) begin
        r_m0_rhold <= mem_dataout;
      end
      if (r_m1_rvalid) begin
        r_m1_rhold <= w_m1_rd_live;
      end
    end
  end

  // Blocked reads return zero on the normal timing
  assign w_m1_rd_live = r_m1_rblk ? '0 : mem_dataout;

  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rvalid ? mem_dataout  : r_m0_rhold;
  assign m1_rdata  = r_m1_rvalid ? w_m1_rd_live : r_m1_rhold;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a
//               read-return scoreboard. Honors DMEM_ARB_IO_PROTECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

`ifdef DMEM_ARB_IO_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] mem_addr, mem_datain, mem_dataout;
  logic        mem_we, arb_err;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_gnt      (m0_gnt),
    .m0_rvalid   (m0_rvalid),
    .m0_rdata    (m0_rdata),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_gnt      (m1_gnt),
    .m1_rvalid   (m1_rvalid),
    .m1_rdata    (m1_rdata),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_we      (mem_we),
    .mem_dataout (mem_dataout),
    .arb_err     (arb_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic blk(input logic [31:0] a);
    return PROT && (a[31:8] == 24'hffffff);
  endfunction

  // Memory model: registered read, one cycle after the address
  always @(posedge clock) mem_dataout <= mem_word(mem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    @(negedge clock);
  endtask

  // Read-return scoreboard
  typedef struct {
    logic        m;
    logic [31:0] d;
    int          cyc;
  } rd_t;

  rd_t         q[$];
  int          cyc = 0;
  logic [31:0] exp0 = '0;
  logic [31:0] exp1 = '0;

  always @(negedge clock) begin
    rd_t e;
    cyc++;
    if (reset) begin
      q.delete();
      exp0 = '0;
      exp1 = '0;
      chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
      chk("rst_m0_rdata", m0_rdata, 32'h0);
      chk("rst_m1_rdata", m1_rdata, 32'h0);
    end else begin
      if (q.size() > 0 && q[0].cyc == cyc - 1) begin
        e = q.pop_front();
        chk("rvalid", {m1_rvalid, m0_rvalid}, e.m ? 2'b10 : 2'b01);
        if (e.m) exp1 = e.d;
        else     exp0 = e.d;
      end else begin
        chk("no_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
      end
      chk("m0_rdata", m0_rdata, exp0);
      chk("m1_rdata", m1_rdata, exp1);
      if (m0_gnt && m0_req && !m0_we) q.push_back('{1'b0, mem_word(m0_addr), cyc});
      if (m1_gnt && m1_req && !m1_we) q.push_back('{1'b1, blk(m1_addr) ? 32'h0 : mem_word(m1_addr), cyc});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    samp(); tick();
    samp(); tick();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      samp(); tick();
    end
  endtask

  initial begin
    int npulse;
    logic [1:0] eg;
    reset = 1'b1;
    clear_inputs();

    // Reset state
    samp();
    chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_datain", mem_datain, 32'h0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_arb_err", arb_err, 1'b0);
    tick();
    reset = 1'b0;

    // A: single m0 read of 0x10
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    samp(); chk("A_c0_gnt", {m1_gnt, m0_gnt}, 2'b00); tick();
    samp();
    chk("A_c1_gnt", {m1_gnt, m0_gnt}, 2'b01);
    chk("A_c1_addr", mem_addr, 32'h10);
    chk("A_c1_we", mem_we, 1'b0);
    tick();
    m0_req = 0;
    samp();
    chk("A_c2_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
    chk("A_c2_rdata", m0_rdata, mem_word(32'h10));
    chk("A_c2_m1_rdata", m1_rdata, 32'h0);
    tick();
    samp(); chk("A_c3_gnt", {m1_gnt, m0_gnt}, 2'b00); tick();

    // B: both request from reset, grant alternates every 4 transfers
    do_reset();
    for (int k = 0; k < 14; k++) begin
      m0_req = 1; m0_we = 0; m0_addr = 32'h100 + 32'(4 * k);
      m1_req = 1; m1_we = 0; m1_addr = 32'h200 + 32'(4 * k);
      samp();
      if (k == 0) eg = 2'b00;
      else        eg = (((k - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("B_gnt_%0d", k), {m1_gnt, m0_gnt}, eg);
      tick();
    end
    clear_inputs();
    idle(2);

    // C: m1 alone, 10 back-to-back writes; m0 joins on the last one
    npulse = 0;
    for (int k = 0; k <= 10; k++) begin
      int idx;
      idx = (k == 0) ? 0 : k - 1;
      m1_req = 1; m1_we = 1;
      m1_addr = 32'h300 + 32'(4 * idx); m1_wdata = 32'hD000 + 32'(idx);
      if (k == 10) begin m0_req = 1; m0_we = 0; m0_addr = 32'h14; end
      samp();
      if (mem_we) npulse++;
      if (k > 0) begin
        chk($sformatf("C_gnt_%0d", k), {m1_gnt, m0_gnt}, 2'b10);
        chk($sformatf("C_addr_%0d", k), mem_addr, 32'h300 + 32'(4 * idx));
        chk($sformatf("C_data_%0d", k), mem_datain, 32'hD000 + 32'(idx));
      end
      tick();
    end
    chk("C_we_pulses", 64'(npulse), 64'd10);

    // D: m0 takes 4 reads ending at 0x20, m1 takes over while it returns
    for (int k = 11; k <= 14; k++) begin
      m0_addr = 32'h14 + 32'(4 * (k - 11));
      m1_addr = 32'h400; m1_wdata = 32'hE000;
      samp();
      chk($sformatf("D_gnt_%0d", k), {m1_gnt, m0_gnt}, 2'b01);
      chk($sformatf("D_we_%0d", k), mem_we, 1'b0);
      tick();
    end
    m0_req = 0;
    samp();
    chk("D_handover_gnt", {m1_gnt, m0_gnt}, 2'b10);
    chk("D_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
    chk("D_rdata", m0_rdata, mem_word(32'h20));
    chk("D_m1_we", mem_we, 1'b1);
    tick();

    // E: reset while an m1 read is in flight
    m1_we = 0; m1_addr = 32'h500;
    samp();
    chk("E_gnt", {m1_gnt, m0_gnt}, 2'b10);
    #1 reset = 1'b1;
    #1;
    chk("E_rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
    chk("E_rst_addr", mem_addr, 32'h0);
    chk("E_rst_we", mem_we, 1'b0);
    chk("E_rst_m1_rdata", m1_rdata, 32'h0);
    tick();
    samp(); tick();
    samp(); tick();
    reset = 1'b0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h600;
    m1_req = 1; m1_we = 0; m1_addr = 32'h700;
    samp(); chk("E_rel_gnt", {m1_gnt, m0_gnt}, 2'b00); tick();
    samp(); chk("E_tie_gnt", {m1_gnt, m0_gnt}, 2'b01); tick();
    clear_inputs();
    idle(3);

    // F: m1 / m0 accesses to the IO window
    m1_req = 1; m1_we = 1; m1_addr = 32'hffffff20; m1_wdata = 32'h7f;
    samp(); chk("F1_gnt", {m1_gnt, m0_gnt}, 2'b00); tick();
    samp();
    chk("F2_gnt", {m1_gnt, m0_gnt}, 2'b10);
    chk("F2_addr", mem_addr, 32'hffffff20);
    chk("F2_data", mem_datain, 32'h7f);
    chk("F2_we", mem_we, !PROT);
    chk("F2_err", arb_err, PROT);
    tick();
    m1_we = 0; m1_addr = 32'hffffff40;
    samp();
    chk("F3_gnt", {m1_gnt, m0_gnt}, 2'b10);
    chk("F3_err", arb_err, PROT);
    chk("F3_we", mem_we, 1'b0);
    tick();
    m1_req = 0;
    samp(); chk("F4_err", arb_err, 1'b0); tick();
    m0_req = 1; m0_we = 1; m0_addr = 32'hffffff20; m0_wdata = 32'h7f;
    samp(); chk("F5_gnt", {m1_gnt, m0_gnt}, 2'b00); tick();
    samp();
    chk("F6_gnt", {m1_gnt, m0_gnt}, 2'b01);
    chk("F6_we", mem_we, 1'b1);
    chk("F6_err", arb_err, 1'b0);
    chk("F6_data", mem_datain, 32'h7f);
    tick();
    clear_inputs();
    idle(3);

    samp();
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
